// File: rtl/paicore_axis_pkg.sv
// rtl/paicore_axis_pkg.sv - shared route-field constants, route code type and route FSM states
package paicore_axis_pkg;

    localparam int ROUTE_LSB_DEF = 60;
    localparam int ROUTE_W_DEF   = 4;

    typedef logic [ROUTE_W_DEF-1:0] route_code_t;

    localparam route_code_t BCAST_CODE_DEF = 4'hF;

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } route_state_t;

endpackage

// File: rtl/axis_skid_buf_2.sv
// rtl/axis_skid_buf_2.sv - two-entry skid buffer: output register plus one overflow register
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_tdata, s_tvalid write side; s_tvalid is a push that the caller guarantees has room
//   s_space_next      fewer than two entries will be held after this edge
//   m_tdata, m_tvalid, m_tready  read side
module axis_skid_buf_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_space_next,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic [1:0]       count_q;
    logic [1:0]       count_nxt;
    logic             pop;

    assign pop      = m_tvalid && m_tready;
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = out_q;

    always_comb begin
        count_nxt = count_q;
        case ({s_tvalid, pop})
            2'b10:   count_nxt = count_q + 2'd1;
            2'b01:   count_nxt = count_q - 2'd1;
            default: count_nxt = count_q;
        endcase
    end

    // Lets the owner register its ready without a combinational path back upstream.
    assign s_space_next = (count_nxt != 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            if (pop) begin
                // Older skid entry moves forward first so ordering holds.
                if (count_q == 2'd2) begin
                    out_q <= skid_q;
                end else if (s_tvalid) begin
                    out_q <= s_tdata;
                end
            end else if (s_tvalid) begin
                if (count_q == 2'd0) begin
                    out_q <= s_tdata;
                end else begin
                    skid_q <= s_tdata;
                end
            end
            count_q <= count_nxt;
        end
    end

endmodule

// File: rtl/axis_fork_route_ctrl.sv
// rtl/axis_fork_route_ctrl.sv - route decode, per-packet fork sideband and invalid-route drop ahead of the fork arbiter
// Ports:
//   clk, rst_n                                      clock, asynchronous active-low reset
//   s_axis_tdata/tlast/tvalid/tready                packet input
//   m_axis_tdata/tlast/tvalid/tready                packet output to the fork arbiter
//   fork_enable, single_mask                        sideband qualified by m_axis_tvalid
//   drop_count, drop_pulse                          dropped-packet statistics
import paicore_axis_pkg::*;

module axis_fork_route_ctrl #(
    parameter int                DATA_WIDTH = 64,
    parameter int                M_COUNT    = 3,
    parameter int                ROUTE_LSB  = ROUTE_LSB_DEF,
    parameter int                ROUTE_W    = ROUTE_W_DEF,
    parameter logic [ROUTE_W-1:0] BCAST_CODE = BCAST_CODE_DEF,
    parameter int                DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    output logic                  fork_enable,
    output logic [M_COUNT-1:0]    single_mask,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  drop_pulse
);

    localparam int SB_W = DATA_WIDTH + 2 + M_COUNT;

    route_state_t         state_q;
    logic                 fe_q;
    logic [M_COUNT-1:0]   mask_q;
    logic                 ready_q;

    logic [ROUTE_W-1:0]   code;
    logic                 code_bcast;
    logic                 code_ok;
    logic [M_COUNT-1:0]   dec_mask;
    logic                 in_head;
    logic                 hs;
    logic                 push;
    logic                 push_fe;
    logic [M_COUNT-1:0]   push_mask;
    logic                 drop_last;
    logic                 drop_next;
    logic                 space_next;
    logic [SB_W-1:0]      sb_out;

    assign s_axis_tready = ready_q;
    assign hs            = s_axis_tvalid && ready_q;
    assign in_head       = (state_q == ST_HEAD);

    assign code       = s_axis_tdata[ROUTE_LSB +: ROUTE_W];
    assign code_bcast = (code == BCAST_CODE);
    assign code_ok    = code_bcast || (int'(code) < M_COUNT);
    assign dec_mask   = code_bcast ? {M_COUNT{1'b1}} : (M_COUNT'(1) << code);

    // Head beats carry the freshly decoded route; body beats reuse the latched one.
    assign push      = hs && ((in_head && code_ok) || (state_q == ST_BODY));
    assign push_fe   = in_head ? code_bcast : fe_q;
    assign push_mask = in_head ? dec_mask : mask_q;

    assign drop_last = hs && s_axis_tlast && ((in_head && !code_ok) || (state_q == ST_DROP));

    // True when the next cycle is spent inside a dropped packet, where the skid
    // is never written, so upstream may keep streaming regardless of backpressure.
    assign drop_next = (in_head && hs && !code_ok && !s_axis_tlast) ||
                       ((state_q == ST_DROP) && !(hs && s_axis_tlast));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HEAD;
            fe_q       <= 1'b0;
            mask_q     <= '0;
            ready_q    <= 1'b0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            ready_q    <= drop_next || space_next;
            drop_pulse <= drop_last;
            if (drop_last && (drop_count != {DROP_CNT_W{1'b1}})) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
            if (hs) begin
                case (state_q)
                    ST_HEAD: begin
                        if (code_ok) begin
                            fe_q    <= code_bcast;
                            mask_q  <= dec_mask;
                            state_q <= s_axis_tlast ? ST_HEAD : ST_BODY;
                        end else begin
                            state_q <= s_axis_tlast ? ST_HEAD : ST_DROP;
                        end
                    end
                    ST_BODY: if (s_axis_tlast) state_q <= ST_HEAD;
                    ST_DROP: if (s_axis_tlast) state_q <= ST_HEAD;
                    default: state_q <= ST_HEAD;
                endcase
            end
        end
    end

    axis_skid_buf_2 #(
        .WIDTH (SB_W)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tdata      ({s_axis_tdata, s_axis_tlast, push_fe, push_mask}),
        .s_tvalid     (push),
        .s_space_next (space_next),
        .m_tdata      (sb_out),
        .m_tvalid     (m_axis_tvalid),
        .m_tready     (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tlast, fork_enable, single_mask} = sb_out;

endmodule

// File: tb/tb_axis_fork_route_ctrl.sv
// tb/tb_axis_fork_route_ctrl.sv - randomized packet-level bench for axis_fork_route_ctrl
module tb_axis_fork_route_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        fork_enable;
    logic [2:0]  single_mask;
    logic [15:0] drop_count;
    logic        drop_pulse;

    always #5 clk = ~clk;

    axis_fork_route_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .fork_enable   (fork_enable),
        .single_mask   (single_mask),
        .drop_count    (drop_count),
        .drop_pulse    (drop_pulse)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        fe;
        logic [2:0]  mask;
    } beat_t;

    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    acc_cyc[$];
    int    obs_cyc[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    int    cyc = 0;
    int    exp_drops = 0;
    int    pulses = 0;
    int    stall_err = 0;
    int    rdy_mode = 0;
    bit    gaps = 0;
    bit    in_acc = 0;
    bit    prev_stall = 0;
    beat_t prev_out;

    function automatic logic [63:0] make_data(input int code);
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[63:60] = code[3:0];
        return d;
    endfunction

    // Packet-level model: route comes from the head's code, drops vanish entirely.
    task automatic add_packet(input int code, input int len);
        bit         drop;
        logic       fe;
        logic [2:0] mask;
        beat_t      b;
        drop = 0;
        fe   = 0;
        mask = 3'b000;
        if (code == 15) begin
            fe   = 1;
            mask = 3'b111;
        end else if (code < 3) begin
            mask = 3'(1 << code);
        end else begin
            drop = 1;
        end
        for (int i = 0; i < len; i++) begin
            b.data = (i == 0) ? make_data(code) : {$urandom, $urandom};
            b.last = (i == len - 1);
            b.fe   = fe;
            b.mask = mask;
            in_q.push_back(b);
            if (!drop) exp_q.push_back(b);
        end
        if (drop) exp_drops++;
    endtask

    task automatic step();
        beat_t cur;
        beat_t b;
        @(negedge clk);
        if (in_acc) s_axis_tvalid = 1'b0;
        if (!s_axis_tvalid && in_q.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
            b = in_q.pop_front();
            s_axis_tdata  = b.data;
            s_axis_tlast  = b.last;
            s_axis_tvalid = 1'b1;
        end
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'b0;
            2:       m_axis_tready = (cyc % 2 == 0);
            default: m_axis_tready = ($urandom_range(0, 2) != 0);
        endcase
        cur = {m_axis_tdata, m_axis_tlast, fork_enable, single_mask};
        if (prev_stall && (!m_axis_tvalid || cur !== prev_out)) stall_err++;
        in_acc = s_axis_tvalid && s_axis_tready;
        if (in_acc) acc_cyc.push_back(cyc);
        if (m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back(cur);
            obs_cyc.push_back(cyc);
        end
        if (drop_pulse) pulses++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = cur;
        cyc++;
    endtask

    task automatic run(input string name, input int max);
        int n;
        n = 0;
        while (!(in_q.size() == 0 && !s_axis_tvalid &&
                 (rdy_mode == 1 || obs_q.size() >= exp_q.size())) && n < max) begin
            step();
            n++;
        end
        tests_run++;
        if (n >= max) begin
            tests_failed++;
            $display("FAIL %s timeout: got %0d cycles, required < %0d", name, n, max);
        end
        repeat (3) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        in_q.delete(); exp_q.delete(); obs_q.delete();
        acc_cyc.delete(); obs_cyc.delete();
        exp_drops = 0; pulses = 0; stall_err = 0;
        in_acc = 0; prev_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {$urandom, $urandom};
        m_axis_tready = 1'b1;
        #1;
        tests_run++;
        if (s_axis_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tready: got %b want 0", s_axis_tready);
        end
        tests_run++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, fork_enable, single_mask} !== '0) begin
            tests_failed++;
            $display("FAIL reset_m_axis: got v=%b d=%h l=%b fe=%b m=%b want all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, fork_enable, single_mask);
        end
        tests_run++;
        if ({drop_count, drop_pulse} !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_drop: got cnt=%0d pulse=%b want 0/0", drop_count, drop_pulse);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_axis_tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_tready: got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_route_single();
        do_reset();
        rdy_mode = 0; gaps = 0;
        add_packet(1, 4);
        run("route_single", 50);
        tests_run++;
        if (obs_q.size() != 4) begin
            tests_failed++;
            $display("FAIL route_single_count: got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL route_single_beat%0d: got %h want %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        tests_run++;
        if (obs_cyc.size() != 4 || acc_cyc.size() != 4 || obs_cyc[0] != acc_cyc[0] + 1 ||
            obs_cyc[3] != obs_cyc[0] + 3) begin
            tests_failed++;
            $display("FAIL route_single_timing: got first=%0d last=%0d acc=%0d want acc+1 and 4 consecutive",
                     (obs_cyc.size() > 0) ? obs_cyc[0] : -1,
                     (obs_cyc.size() > 3) ? obs_cyc[3] : -1,
                     (acc_cyc.size() > 0) ? acc_cyc[0] : -1);
        end
    endtask

    task automatic test_bcast_then_single();
        do_reset();
        rdy_mode = 0; gaps = 0;
        add_packet(15, 1);
        add_packet(0, 1);
        run("bcast_single", 50);
        tests_run++;
        if (obs_q.size() != 2 || {obs_q[0].fe, obs_q[0].mask, obs_q[1].fe, obs_q[1].mask} !== 8'b1111_0001) begin
            tests_failed++;
            $display("FAIL bcast_single_sideband: got n=%0d want fe/mask 1/111 then 0/001", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bcast_single_beat%0d: got %h want %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        tests_run++;
        if (obs_cyc.size() != 2 || obs_cyc[1] != obs_cyc[0] + 1) begin
            tests_failed++;
            $display("FAIL bcast_single_consecutive: got %0d beats, want 2 on consecutive cycles", obs_cyc.size());
        end
    endtask

    task automatic test_drop_stalled();
        do_reset();
        rdy_mode = 1; gaps = 0;
        add_packet(0, 1);
        add_packet(5, 3);
        run("drop_stalled", 50);
        tests_run++;
        if (obs_q.size() != 0 || acc_cyc.size() != 4 || acc_cyc[3] != acc_cyc[1] + 2) begin
            tests_failed++;
            $display("FAIL drop_stalled_drain: got out=%0d accepted=%0d want out=0 accepted=4 back-to-back",
                     obs_q.size(), acc_cyc.size());
        end
        tests_run++;
        if (s_axis_tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_stalled_tready: got %b want 1", s_axis_tready);
        end
        tests_run++;
        if (pulses != 1 || drop_count !== 16'(exp_drops)) begin
            tests_failed++;
            $display("FAIL drop_stalled_count: got pulses=%0d cnt=%0d want 1/%0d", pulses, drop_count, exp_drops);
        end
        rdy_mode = 0;
        run("drop_release", 50);
        tests_run++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL drop_release_beat: got n=%0d want 1 beat %h", obs_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy_mode = 1; gaps = 0;
        add_packet(1, 4);
        repeat (10) step();
        tests_run++;
        if (acc_cyc.size() != 2 || s_axis_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_fill: got accepted=%0d tready=%b want 2/0", acc_cyc.size(), s_axis_tready);
        end
        tests_run++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[0].data) begin
            tests_failed++;
            $display("FAIL bp_hold: got v=%b d=%h want 1/%h", m_axis_tvalid, m_axis_tdata, exp_q[0].data);
        end
        rdy_mode = 2;
        run("bp_drain", 100);
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bp_beat%0d: got %h want %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_toggle();
        do_reset();
        rdy_mode = 2; gaps = 0;
        add_packet(2, 8);
        run("toggle", 200);
        tests_run++;
        if (obs_q.size() != 8 || stall_err != 0) begin
            tests_failed++;
            $display("FAIL toggle_stream: got n=%0d stall_err=%0d want 8/0", obs_q.size(), stall_err);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL toggle_beat%0d: got %h want %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        beat_t b;
        int    n;
        do_reset();
        rdy_mode = 0; gaps = 0;
        for (int i = 0; i < 2; i++) begin
            b.data = (i == 0) ? make_data(1) : {$urandom, $urandom};
            b.last = 1'b0; b.fe = 1'b0; b.mask = 3'b010;
            in_q.push_back(b);
        end
        n = 0;
        while (acc_cyc.size() < 2 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (acc_cyc.size() != 2) begin
            tests_failed++;
            $display("FAIL midrst_pre: got accepted=%0d want 2", acc_cyc.size());
        end
        do_reset();
        add_packet(2, 3);
        run("midrst", 50);
        tests_run++;
        if (obs_q.size() != 3 || obs_q[0].mask !== 3'b100 || obs_q[0].fe !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_head: got n=%0d want 3 beats with mask 100", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL midrst_beat%0d: got %h want %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        int code;
        do_reset();
        rdy_mode = 3; gaps = 1;
        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      code = $urandom_range(0, 2);
            else if (r < 8) code = 15;
            else            code = $urandom_range(3, 14);
            add_packet(code, $urandom_range(1, 6));
        end
        run("random", 5000);
        tests_run++;
        if (obs_q.size() != exp_q.size() || stall_err != 0) begin
            tests_failed++;
            $display("FAIL random_stream: got n=%0d stall_err=%0d want %0d/0", obs_q.size(), stall_err, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL random_beat%0d: got %h want %h", i,
                         (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        tests_run++;
        if (pulses != exp_drops || drop_count !== 16'(exp_drops)) begin
            tests_failed++;
            $display("FAIL random_drops: got pulses=%0d cnt=%0d want %0d", pulses, drop_count, exp_drops);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        test_reset();
        test_route_single();
        test_bcast_then_single();
        test_drop_stalled();
        test_backpressure();
        test_toggle();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
